// File: rtl/dense_layer_if.sv
// Data bus of dense_layer: input vector, weight matrix, bias vector and registered result.
interface dense_layer_if #(
  parameter int unsigned WIDTH       = 17,
  parameter int unsigned INPUT_SIZE  = 32,
  parameter int unsigned OUTPUT_SIZE = 32
);
  logic signed [WIDTH-1:0] input_data  [INPUT_SIZE];
  logic signed [WIDTH-1:0] weights     [INPUT_SIZE][OUTPUT_SIZE];
  logic signed [WIDTH-1:0] bias        [OUTPUT_SIZE];
  logic signed [WIDTH-1:0] output_data [OUTPUT_SIZE];

  modport master (
    output input_data, weights, bias,
    input  output_data
  );

  modport slave (
    input  input_data, weights, bias,
    output output_data
  );
endinterface

// File: rtl/dense_layer.sv
// Pipelined fixed-point dense layer y = b + sum(trunc(x*W)); multiply stage, binary adder tree, bias + output register.
// Optional macro DENSE_THREE_CYCLE_MULT_EN adds two register stages after the multiply register.
module dense_layer #(
  parameter int unsigned WIDTH       = 17,
  parameter int unsigned NFRAC       = 10,
  parameter int unsigned INPUT_SIZE  = 32,
  parameter int unsigned OUTPUT_SIZE = 32
) (
  input  logic          clk,
  input  logic          reset,
  dense_layer_if.slave  bus
);

  localparam int unsigned L  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 0;
  localparam int unsigned PW = 2 * WIDTH;

  // Number of live operands at tree level k.
  function automatic int unsigned lvl_cnt(input int unsigned k);
    int unsigned n;
    n = INPUT_SIZE;
    for (int unsigned m = 0; m < k; m++) n = (n + 1) / 2;
    return n;
  endfunction

  // Clamp operand indices so dead branches never reference out of range.
  function automatic int unsigned safe_idx(input int unsigned i);
    return (i < INPUT_SIZE) ? i : 0;
  endfunction

  logic signed [WIDTH-1:0] prod [OUTPUT_SIZE][INPUT_SIZE];
  logic signed [WIDTH-1:0] tree [OUTPUT_SIZE][L+1][INPUT_SIZE];
`ifdef DENSE_THREE_CYCLE_MULT_EN
  logic signed [WIDTH-1:0] mult_d1 [OUTPUT_SIZE][INPUT_SIZE];
  logic signed [WIDTH-1:0] mult_d2 [OUTPUT_SIZE][INPUT_SIZE];
`endif

  // Arithmetic shift of the full product floors the dropped LSBs; the cast wraps the MSBs.
  always_comb begin
    for (int unsigned j = 0; j < OUTPUT_SIZE; j++) begin
      for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
        logic signed [PW-1:0] p;
        p = PW'(bus.input_data[i]) * PW'(bus.weights[i][j]);
        prod[j][i] = WIDTH'(p >>> NFRAC);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tree    <= '{default: '0};
`ifdef DENSE_THREE_CYCLE_MULT_EN
      mult_d1 <= '{default: '0};
      mult_d2 <= '{default: '0};
`endif
    end else begin
`ifdef DENSE_THREE_CYCLE_MULT_EN
      mult_d1 <= prod;
      mult_d2 <= mult_d1;
`endif
      for (int unsigned j = 0; j < OUTPUT_SIZE; j++) begin
        for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
`ifdef DENSE_THREE_CYCLE_MULT_EN
          tree[j][0][i] <= mult_d2[j][i];
`else
          tree[j][0][i] <= prod[j][i];
`endif
        end
        // Level k pairs operands 2i/2i+1 of level k-1; an odd leftover is passed through.
        for (int unsigned k = 1; k <= L; k++) begin
          for (int unsigned i = 0; i < INPUT_SIZE; i++) begin
            if (i < lvl_cnt(k)) begin
              if (2 * i + 1 < lvl_cnt(k - 1))
                tree[j][k][i] <= tree[j][k-1][safe_idx(2*i)] + tree[j][k-1][safe_idx(2*i+1)];
              else
                tree[j][k][i] <= tree[j][k-1][safe_idx(2*i)];
            end else begin
              tree[j][k][i] <= '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned j = 0; j < OUTPUT_SIZE; j++) bus.output_data[j] <= '0;
    end else begin
      for (int unsigned j = 0; j < OUTPUT_SIZE; j++)
        bus.output_data[j] <= tree[j][L][0] + bus.bias[j];
    end
  end

endmodule

// File: tb/tb_dense_layer.sv
// Directed bench for dense_layer: basic, bias, wrap, truncation, latency and mid-stream reset.
module tb_dense_layer;

`ifdef DENSE_THREE_CYCLE_MULT_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT_A = 3 + 2 + EXTRA;
  localparam int LAT_W = 1 + 2 + EXTRA;
  localparam int LAT_T = 0 + 2 + EXTRA;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  dense_layer_if #(.WIDTH(8), .INPUT_SIZE(7), .OUTPUT_SIZE(5)) a_if ();
  dense_layer_if #(.WIDTH(8), .INPUT_SIZE(2), .OUTPUT_SIZE(1)) w_if ();
  dense_layer_if #(.WIDTH(8), .INPUT_SIZE(1), .OUTPUT_SIZE(1)) t_if ();

  dense_layer #(.WIDTH(8), .NFRAC(0), .INPUT_SIZE(7), .OUTPUT_SIZE(5))
    u_a (.clk(clk), .reset(reset), .bus(a_if.slave));
  dense_layer #(.WIDTH(8), .NFRAC(0), .INPUT_SIZE(2), .OUTPUT_SIZE(1))
    u_w (.clk(clk), .reset(reset), .bus(w_if.slave));
  dense_layer #(.WIDTH(8), .NFRAC(4), .INPUT_SIZE(1), .OUTPUT_SIZE(1))
    u_t (.clk(clk), .reset(reset), .bus(t_if.slave));

  logic signed [7:0] xv [7] = '{-1, 2, -3, 4, -5, 6, -7};
  logic signed [7:0] wv [7][5] = '{'{1, 2, 3, 4, 5}, '{3, 4, 5, 6, 7}, '{5, 6, 7, 8, 9},
                                   '{7, 8, 9, 0, 1}, '{9, 0, 1, 2, 3}, '{1, 2, 3, 4, 5},
                                   '{3, 4, 5, 6, 7}};
  logic signed [7:0] bv       [5] = '{1, 2, 3, 4, 5};
  logic signed [7:0] zero5    [5] = '{0, 0, 0, 0, 0};
  logic signed [7:0] y_basic  [5] = '{-42, 4, 0, -44, -48};
  logic signed [7:0] y_bias   [5] = '{-41, 6, 3, -40, -43};
  logic signed [7:0] y_negb   [5] = '{43, -2, 3, 48, 53};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic chk_a(input string tag, input logic signed [7:0] exp [5]);
    for (int j = 0; j < 5; j++)
      chk($sformatf("%s[%0d]", tag, j), a_if.output_data[j], exp[j]);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_x(input int s);
    for (int i = 0; i < 7; i++) a_if.input_data[i] = 8'(s * int'(xv[i]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    drive_x(0);
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 5; j++) a_if.weights[i][j] = wv[i][j];
    for (int j = 0; j < 5; j++) a_if.bias[j] = '0;
    w_if.input_data[0] = 8'sd100;
    w_if.input_data[1] = 8'sd100;
    w_if.weights[0][0] = 8'sd1;
    w_if.weights[1][0] = 8'sd1;
    w_if.bias[0]       = '0;
    t_if.input_data[0] = '0;
    t_if.weights[0][0] = '0;
    t_if.bias[0]       = '0;

    #2;
    chk_a("reset_a", zero5);
    chk("reset_w", w_if.output_data[0], 8'h00);
    chk("reset_t", t_if.output_data[0], 8'h00);

    @(negedge clk);
    reset = 1'b1;
    tick(LAT_A + 1);

    // Exact latency: still zero one cycle early, result on the expected edge.
    drive_x(1);
    tick(LAT_A - 1);
    chk_a("early", zero5);
    tick(1);
    chk_a("basic", y_basic);

    for (int j = 0; j < 5; j++) a_if.bias[j] = bv[j];
    tick(1);
    chk_a("bias", y_bias);

    chk("wrap", w_if.output_data[0], 8'hC8);

    t_if.input_data[0] = 8'h18;
    t_if.weights[0][0] = 8'h18;
    tick(LAT_T);
    chk("trunc_pos", t_if.output_data[0], 8'h24);
    t_if.input_data[0] = 8'h01;
    t_if.weights[0][0] = 8'h08;
    tick(LAT_T);
    chk("trunc_zero", t_if.output_data[0], 8'h00);
    t_if.input_data[0] = 8'hFF;
    t_if.weights[0][0] = 8'h08;
    tick(LAT_T);
    chk("trunc_floor", t_if.output_data[0], 8'hFF);

    // Fill the pipeline with -x, then reset between clock edges.
    drive_x(-1);
    tick(3);
    #2;
    reset = 1'b0;
    #1;
    chk_a("rst_clear", zero5);
    chk("rst_clear_w", w_if.output_data[0], 8'h00);
    chk("rst_clear_t", t_if.output_data[0], 8'h00);
    drive_x(1);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= LAT_A - 1; k++) begin
      tick(1);
      chk_a($sformatf("post_rst_bias%0d", k), bv);
      if (k == 1) drive_x(-1);
      if (k == 2) drive_x(1);
    end
    tick(1);
    chk_a("stream0", y_bias);
    tick(1);
    chk_a("stream1", y_negb);
    tick(1);
    chk_a("stream2", y_bias);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dense_layer.md
DENSE_LAYER -- requirements
Module: dense_layer

Interface
REQ-001 Parameter WIDTH, default 17: signed two's-complement fixed-point word width.
REQ-002 Parameter NFRAC, default 10: fractional bits; 0 <= NFRAC < WIDTH.
REQ-003 Parameter INPUT_SIZE, default 32: number of input words; >= 1.
REQ-004 Parameter OUTPUT_SIZE, default 32: number of output words; >= 1.
REQ-005 clk  input  1  the single clock; all registers update on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 input_data  input  signed WIDTH x [INPUT_SIZE]  input vector x.
REQ-008 weights  input  signed WIDTH x [INPUT_SIZE][OUTPUT_SIZE]  weight matrix W[row=input][col=output].
REQ-009 bias  input  signed WIDTH x [OUTPUT_SIZE]  bias vector b.
REQ-010 output_data  output  signed WIDTH x [OUTPUT_SIZE]  registered result y.

Function
REQ-011 The block SHALL compute y[j] = b[j] + sum over i of trunc(x[i]*W[i][j]) for every j.
REQ-012 Each product SHALL be the full signed 2*WIDTH-bit product, keeping bits [WIDTH+NFRAC-1:NFRAC]; discarded LSBs truncate toward minus infinity; discarded MSBs wrap with no saturation.
REQ-013 Products SHALL be registered in one multiply stage.
REQ-014 Summation SHALL use a pipelined binary adder tree of L = ceil(log2(INPUT_SIZE)) register stages, with L = 0 when INPUT_SIZE = 1; at each level an odd leftover operand passes to the next level through a register.
REQ-015 All sums SHALL be WIDTH bits wide and wrap modulo 2^WIDTH, with no saturation or overflow flag.
REQ-016 The bias SHALL be added combinationally to the tree output, wrapping modulo 2^WIDTH, and the result SHALL be registered into output_data.
REQ-017 Latency from input_data to output_data SHALL be L+2 cycles; for example, INPUT_SIZE=7 gives 5 cycles.
REQ-018 The block SHALL be fully pipelined with no handshake, accepting a new input vector every cycle and producing one result per cycle.
REQ-019 weights and bias SHALL be sampled in the same cycle as the products and the bias addition they contribute to, respectively, and SHALL be held stable by the user for deterministic results.

Reset
REQ-020 While reset = 0, all pipeline registers and output_data SHALL clear to 0 immediately, independent of clk.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight data.
REQ-022 After release, output_data SHALL equal b for L+1 cycles, because the zeroed tree output flows through the bias adder; the first real result SHALL appear L+2 cycles after the first post-reset input edge.

Configuration
REQ-023 When macro DENSE_THREE_CYCLE_MULT_EN is defined, two additional register stages SHALL follow the multiply register, so that the multiplier maps to a 3-cycle DSP, and latency SHALL become L+4.
REQ-024 When DENSE_THREE_CYCLE_MULT_EN is undefined, latency SHALL be L+2 and results SHALL be otherwise identical.

Verification
REQ-025 Basic test: WIDTH=8, NFRAC=0, INPUT_SIZE=7, OUTPUT_SIZE=5; x={-1,2,-3,4,-5,6,-7}; W rows {1,2,3,4,5},{3,4,5,6,7},{5,6,7,8,9},{7,8,9,0,1},{9,0,1,2,3},{1,2,3,4,5},{3,4,5,6,7}; b=0 -> y={-42,4,0,-44,-48} after exactly 5 cycles.
REQ-026 Bias test: same stimulus with b={1,2,3,4,5} -> y={-41,6,3,-40,-43}.
REQ-027 Wrap test: WIDTH=8, NFRAC=0, INPUT_SIZE=2, x={100,100}, W=1, b=0 -> y=-56.
REQ-028 Truncation test: WIDTH=8, NFRAC=4, INPUT_SIZE=1, b=0; x=0x18, W=0x18 -> 0x24; x=0x01, W=0x08 -> 0x00; x=0xFF, W=0x08 -> 0xFF.
REQ-029 Reset test: assert reset mid-stream -> output_data=0 immediately; after release, output_data=b for L+1 cycles, then valid results every cycle on back-to-back vectors.
REQ-030 Configuration test: DENSE_THREE_CYCLE_MULT_EN defined with REQ-025 stimulus -> same y, delivered after 7 cycles.
